// File: rtl/serial_add_pkg.sv
// Shared types and constants for the nibble-serial add/sub/PADDSB sequencer.
package serial_add_pkg;

    localparam int NIB_W   = 4;
    localparam int NUM_NIB = 4;
    localparam int WORD_W  = NIB_W * NUM_NIB;

    typedef enum logic [1:0] {
        OP_ADD    = 2'b00,
        OP_SUB    = 2'b01,
        OP_PADDSB = 2'b10
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

    localparam logic [WORD_W-1:0] SAT_POS16 = 16'h7FFF;
    localparam logic [WORD_W-1:0] SAT_NEG16 = 16'h8000;
    localparam logic [NIB_W-1:0]  SAT_POS4  = 4'h7;
    localparam logic [NIB_W-1:0]  SAT_NEG4  = 4'h8;

    // The unused 2'b11 encoding falls back to ADD.
    function automatic op_e decode_op(input logic [1:0] raw);
        case (raw)
            2'b01:   return OP_SUB;
            2'b10:   return OP_PADDSB;
            default: return OP_ADD;
        endcase
    endfunction

endpackage

// File: rtl/nibble_cla_slice.sv
// Purely combinational 4-bit carry-lookahead adder slice (generate/propagate form).
module nibble_cla_slice
    import serial_add_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             cin,
    output logic [NIB_W-1:0] sum,
    output logic             cout
);

    logic [NIB_W-1:0] g;
    logic [NIB_W-1:0] p;
    logic [NIB_W:0]   c;

    assign g = a & b;
    assign p = a ^ b;

    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

    assign sum  = p ^ c[NIB_W-1:0];
    assign cout = c[NIB_W];

endmodule

// File: rtl/serial_add_ctrl.sv
// 16-bit ADD/SUB/PADDSB computed over four cycles on one shared nibble slice.
// Define SERIAL_ADD_SAT_EN to saturate ADD/SUB on word overflow (otherwise they wrap).
module serial_add_ctrl
    import serial_add_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [WORD_W-1:0] result,
    output logic              v,
    output logic              n,
    output logic              z
);

    state_e            state_q, state_d;
    logic [1:0]        nib_cnt_q;
    logic              cin_q;
    logic              nov_q;
    op_e               op_q;
    logic [WORD_W-1:0] a_q, b_q;
    logic [11:0]       sum_q;
    logic [WORD_W-1:0] result_q;
    logic              v_q, n_q, z_q;

    logic              start_acc, last_nib;
    logic [3:0]        nib_base;
    logic [NIB_W-1:0]  a_nib, b_nib, s_nib, nib_wr;
    logic              slice_cin, s_cout, nib_ov, word_ov, fin_v;
    logic [WORD_W-1:0] word_raw, fin_res;

    assign start_acc = (state_q == IDLE) && start;
    assign last_nib  = (state_q == RUN) && (nib_cnt_q == 2'(NUM_NIB - 1));

    assign nib_base  = {nib_cnt_q, 2'b00};
    assign a_nib     = a_q[nib_base +: NIB_W];
    assign b_nib     = b_q[nib_base +: NIB_W];
    assign slice_cin = (op_q == OP_PADDSB) ? 1'b0 : cin_q;

    nibble_cla_slice u_slice (
        .a    (a_nib),
        .b    (b_nib),
        .cin  (slice_cin),
        .sum  (s_nib),
        .cout (s_cout)
    );

    assign nib_ov = (a_nib[NIB_W-1] == b_nib[NIB_W-1]) && (s_nib[NIB_W-1] != a_nib[NIB_W-1]);
    assign nib_wr = ((op_q == OP_PADDSB) && nib_ov) ? (a_nib[NIB_W-1] ? SAT_NEG4 : SAT_POS4)
                                                    : s_nib;

    // Top nibble is still on the slice output when the word result is formed.
    assign word_raw = {nib_wr, sum_q};
    assign word_ov  = (a_q[WORD_W-1] == b_q[WORD_W-1]) && (word_raw[WORD_W-1] != a_q[WORD_W-1]);
    assign fin_v    = (op_q == OP_PADDSB) ? (nov_q | nib_ov) : word_ov;

`ifdef SERIAL_ADD_SAT_EN
    assign fin_res = ((op_q != OP_PADDSB) && word_ov) ? (a_q[WORD_W-1] ? SAT_NEG16 : SAT_POS16)
                                                      : word_raw;
`else
    assign fin_res = word_raw;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)    state_d = RUN;
            RUN:     if (last_nib) state_d = DONE;
            DONE:                  state_d = IDLE;
            default:               state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != IDLE);
        done = (state_q == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nib_cnt_q <= '0;
            cin_q     <= 1'b0;
            nov_q     <= 1'b0;
            result_q  <= '0;
            v_q       <= 1'b0;
            n_q       <= 1'b0;
            z_q       <= 1'b0;
        end else if (start_acc) begin
            nib_cnt_q <= '0;
            cin_q     <= (decode_op(op) == OP_SUB);
            nov_q     <= 1'b0;
        end else if (state_q == RUN) begin
            nib_cnt_q <= nib_cnt_q + 2'd1;
            cin_q     <= s_cout;
            nov_q     <= nov_q | ((op_q == OP_PADDSB) && nib_ov);
            if (last_nib) begin
                result_q <= fin_res;
                v_q      <= fin_v;
                n_q      <= fin_res[WORD_W-1];
                z_q      <= (fin_res == '0);
            end
        end
    end

    // Operand and partial-sum storage needs no reset: it is always loaded before use.
    always_ff @(posedge clk) begin
        if (start_acc) begin
            a_q  <= a;
            b_q  <= (decode_op(op) == OP_SUB) ? ~b : b;
            op_q <= decode_op(op);
        end else if (state_q == RUN) begin
            case (nib_cnt_q)
                2'd0:    sum_q[3:0]  <= nib_wr;
                2'd1:    sum_q[7:4]  <= nib_wr;
                2'd2:    sum_q[11:8] <= nib_wr;
                default: ;
            endcase
        end
    end

    assign result = result_q;
    assign v      = v_q;
    assign n      = n_q;
    assign z      = z_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Randomized and directed bench for serial_add_ctrl against an arithmetic reference model.
module tb_serial_add_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start_i;
    logic [1:0]  op_i;
    logic [15:0] a_i, b_i;
    logic        busy, done;
    logic [15:0] result;
    logic        v, n, z;

    int vectors     = 0;
    int miscompares = 0;

    serial_add_ctrl dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start_i),
        .op     (op_i),
        .a      (a_i),
        .b      (b_i),
        .busy   (busy),
        .done   (done),
        .result (result),
        .v      (v),
        .n      (n),
        .z      (z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: signed arithmetic on whole values, returns {v, result}.
    function automatic logic [16:0] model(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y);
        int sa, sb, r;
        logic [15:0] res;
        logic ov;
        ov  = 1'b0;
        res = '0;
        if (o == 2'b10) begin
            for (int i = 0; i < 4; i++) begin
                sa = x[i*4+3] ? int'(x[i*4 +: 4]) - 16 : int'(x[i*4 +: 4]);
                sb = y[i*4+3] ? int'(y[i*4 +: 4]) - 16 : int'(y[i*4 +: 4]);
                r  = sa + sb;
                if (r > 7) begin r = 7; ov = 1'b1; end
                else if (r < -8) begin r = -8; ov = 1'b1; end
                res[i*4 +: 4] = r[3:0];
            end
        end else begin
            sa = x[15] ? int'(x) - 65536 : int'(x);
            sb = y[15] ? int'(y) - 65536 : int'(y);
            r  = (o == 2'b01) ? sa - sb : sa + sb;
            if (r > 32767 || r < -32768) begin
                ov = 1'b1;
`ifdef SERIAL_ADD_SAT_EN
                r = (r > 0) ? 32767 : -32768;
`endif
            end
            res = r[15:0];
        end
        return {ov, res};
    endfunction

    task automatic wait_idle();
        int guard = 0;
        @(negedge clk);
        while (busy && guard < 20) begin
            @(negedge clk);
            guard++;
        end
    endtask

    // Issues one operation and returns the cycle count from the start edge to done.
    task automatic do_op(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y,
                         output int lat, output logic busy_ok);
        wait_idle();
        op_i = o; a_i = x; b_i = y; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        a_i = 16'($urandom);
        b_i = 16'($urandom);
        op_i = 2'($urandom);
        lat = 1;
        busy_ok = 1'b1;
        while (!done && lat < 20) begin
            if (!busy) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        #1;
        vectors++;
        if ({result, v, n, z, busy, done} !== 21'h0) begin
            miscompares++;
            $display("FAIL reset_state: got res=%h v=%b n=%b z=%b busy=%b done=%b required all 0",
                     result, v, n, z, busy, done);
        end
    endtask

    task automatic test_directed();
        logic [1:0]  t_op [7];
        logic [15:0] t_a  [7];
        logic [15:0] t_b  [7];
        logic [15:0] t_r  [7];
        logic        t_v  [7];
        int lat;
        logic bok;
        t_op = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b10, 2'b11};
        t_a  = '{16'h1234, 16'h7FFF, 16'h0000, 16'h8000, 16'h0005, 16'h7F18, 16'h0001};
        t_b  = '{16'h0111, 16'h0001, 16'h0001, 16'h0001, 16'h0005, 16'h1181, 16'h0002};
`ifdef SERIAL_ADD_SAT_EN
        t_r  = '{16'h1345, 16'h7FFF, 16'hFFFF, 16'h8000, 16'h0000, 16'h7099, 16'h0003};
`else
        t_r  = '{16'h1345, 16'h8000, 16'hFFFF, 16'h7FFF, 16'h0000, 16'h7099, 16'h0003};
`endif
        t_v  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 7; i++) begin
            do_op(t_op[i], t_a[i], t_b[i], lat, bok);
            vectors++;
            if (lat !== 5) begin
                miscompares++;
                $display("FAIL dir_latency[%0d]: got %0d cycles required 5", i, lat);
            end
            vectors++;
            if (!bok) begin
                miscompares++;
                $display("FAIL dir_busy[%0d]: busy dropped during RUN, required high", i);
            end
            vectors++;
            if ({result, v, n, z} !== {t_r[i], t_v[i], t_r[i][15], (t_r[i] == 16'h0)}) begin
                miscompares++;
                $display("FAIL dir_result[%0d]: got res=%h v=%b n=%b z=%b required res=%h v=%b n=%b z=%b",
                         i, result, v, n, z, t_r[i], t_v[i], t_r[i][15], (t_r[i] == 16'h0));
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] edge_v [4];
        logic [1:0]  o;
        logic [15:0] x, y, held;
        logic [16:0] exp;
        int lat;
        logic bok;
        edge_v = '{16'h7FFF, 16'h8000, 16'hFFFF, 16'h0000};
        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom_range(0, 3));
            x = ($urandom_range(0, 3) == 0) ? edge_v[$urandom_range(0, 3)] : 16'($urandom);
            y = ($urandom_range(0, 3) == 0) ? edge_v[$urandom_range(0, 3)] : 16'($urandom);
            exp = model(o, x, y);
            do_op(o, x, y, lat, bok);
            vectors++;
            if (lat !== 5 || !bok) begin
                miscompares++;
                $display("FAIL rnd_timing[%0d]: got latency=%0d busy_ok=%b required 5/1", i, lat, bok);
            end
            vectors++;
            if ({result, v, n, z} !== {exp[15:0], exp[16], exp[15], (exp[15:0] == 16'h0)}) begin
                miscompares++;
                $display("FAIL rnd_result[%0d] op=%0d a=%h b=%h: got res=%h v=%b n=%b z=%b required res=%h v=%b",
                         i, o, x, y, result, v, n, z, exp[15:0], exp[16]);
            end
            held = result;
            @(posedge clk); #1;
            vectors++;
            if (done !== 1'b0 || result !== held) begin
                miscompares++;
                $display("FAIL rnd_hold[%0d]: got done=%b res=%h required done=0 res=%h", i, done, result, held);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [16:0] e1, e2;
        logic [15:0] r1, r2;
        logic        v1, v2, busy_ok;
        int          d1, d2, nd;
        e1 = model(2'b00, 16'h4321, 16'h1111);
        e2 = model(2'b01, 16'h1000, 16'h2345);
        d1 = -1; d2 = -1; nd = 0; busy_ok = 1'b1;
        r1 = '0; r2 = '0; v1 = 1'b0; v2 = 1'b0;
        wait_idle();
        op_i = 2'b00; a_i = 16'h4321; b_i = 16'h1111; start_i = 1'b1;
        @(posedge clk); #1;
        op_i = 2'b01; a_i = 16'h1000; b_i = 16'h2345;
        for (int i = 0; i <= 12; i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            if (i == 6) start_i = 1'b0;
            if ((i <= 4 || (i >= 6 && i <= 10)) && !busy) busy_ok = 1'b0;
            if (done) begin
                nd++;
                if (d1 < 0) begin d1 = i; r1 = result; v1 = v; end
                else begin d2 = i; r2 = result; v2 = v; end
            end
        end
        vectors++;
        if (nd !== 2 || d1 !== 4 || d2 !== 10) begin
            miscompares++;
            $display("FAIL b2b_timing: got %0d done pulses at %0d,%0d required 2 at 4,10", nd, d1, d2);
        end
        vectors++;
        if (!busy_ok) begin
            miscompares++;
            $display("FAIL b2b_busy: busy dropped during RUN, required high");
        end
        vectors++;
        if ({v1, r1, v2, r2} !== {e1, e2}) begin
            miscompares++;
            $display("FAIL b2b_result: got %h/%b %h/%b required %h/%b %h/%b",
                     r1, v1, r2, v2, e1[15:0], e1[16], e2[15:0], e2[16]);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        logic bok, saw_done;
        logic [16:0] exp;
        do_op(2'b00, 16'h1234, 16'h0111, lat, bok);
        wait_idle();
        op_i = 2'b00; a_i = 16'h0F0F; b_i = 16'h0101; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({result, v, n, z, busy, done} !== 21'h0) begin
            miscompares++;
            $display("FAIL midreset_state: got res=%h v=%b n=%b z=%b busy=%b done=%b required all 0",
                     result, v, n, z, busy, done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
        end
        vectors++;
        if (saw_done) begin
            miscompares++;
            $display("FAIL midreset_nodone: got a done pulse after abort, required none");
        end
        exp = model(2'b01, 16'h0050, 16'h0003);
        do_op(2'b01, 16'h0050, 16'h0003, lat, bok);
        vectors++;
        if (lat !== 5 || {v, result} !== exp) begin
            miscompares++;
            $display("FAIL midreset_next: got lat=%0d res=%h v=%b required lat=5 res=%h v=%b",
                     lat, result, v, exp[15:0], exp[16]);
        end
    endtask

    initial begin
        rst_n = 1'b0; start_i = 1'b0; op_i = 2'b00; a_i = '0; b_i = '0;
        repeat (3) @(posedge clk);
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Multi-cycle sequencer that computes 16-bit ADD, SUB and PADDSB results by time-sharing one 4-bit carry-lookahead nibble slice over four cycles, least-significant nibble first. It sits beside the ALU as a low-area add/sub unit. It owns operand latching, carry chaining, overflow detection and saturation. It reports completion through a start/done handshake.

## Interface
- NIB_W, 4, nibble slice width; fixed, not for override.
- NUM_NIB, 4, nibbles per 16-bit word.
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  request; sampled only in IDLE.
- op  in  2  operation: 2'b00 ADD, 2'b01 SUB, 2'b10 PADDSB, 2'b11 treated as ADD.
- a  in  16  operand A; sampled with start.
- b  in  16  operand B; sampled with start.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse; result and flags are valid from this cycle.
- result  out  16  final, saturated result; held until the next completion.
- v  out  1  overflow: any nibble for PADDSB, word-level for ADD/SUB.
- n  out  1  result[15].
- z  out  1  result == 16'h0000.

## Operation
- FSM states and transitions:
  - IDLE -> RUN when start=1. On that edge, latch a, op and b_eff (b, or ~b for SUB), set cin_q (1 for SUB, else 0) and nib_cnt=0.
  - RUN: the slice adds a_q[nib] + b_eff[nib] + cin. Sum goes to sum_q[nib], cout goes to cin_q, nib_cnt increments. RUN -> DONE after nib_cnt=3.
  - DONE: outputs are updated and done=1. DONE -> IDLE unconditionally.
- Slice carry-in:
  - ADD/SUB: carry is chained, so each nibble's cin is the previous nibble's cout.
  - PADDSB: cin is forced to 0 on every nibble, so there is no inter-nibble carry.
- Per-nibble overflow (PADDSB): the operand signs a[3], b[3] match and sum[3] differs from them. On overflow the nibble saturates to 4'h7 if a-sign is 0, else 4'h8.
- Word overflow (ADD/SUB): a_q[15] == b_eff[15] and sum_q[15] differs. On overflow the result saturates to 16'h7FFF if a_q[15]=0, else 16'h8000 (see Configuration).
- Per-nibble saturation is applied as each nibble is written. Word saturation, v, n and z are applied when entering DONE.
- start while busy is ignored; no queueing.
- Operand inputs may change freely after the start cycle.
- Reset, including mid-operation:
  - state=IDLE, nib_cnt=0, cin_q=0.
  - result=0, v=0, n=0, z=0, busy=0, done=0.
  - The aborted operation never pulses done.

## Timing
- Cycle T: start=1 sampled in IDLE.
- Cycles T+1..T+4: RUN, nibbles 0..3; busy=1.
- Cycle T+5: DONE; done=1, busy=1, outputs valid.
- Cycle T+6: IDLE; earliest next start accepted here, giving 6-cycle throughput and 5-cycle latency.
- result/v/n/z are registered and change only on the edge entering DONE; they are stable otherwise.
- No combinational path from inputs to outputs.

## Configuration
- SERIAL_ADD_SAT_EN defined: ADD/SUB saturate on word overflow as described above.
- SERIAL_ADD_SAT_EN undefined:
  - ADD/SUB wrap; result is the raw 16-bit sum.
  - v is still reported.
  - PADDSB saturation is unaffected.

## Structure
- Shared package serial_add_pkg:
  - op enum: OP_ADD, OP_SUB, OP_PADDSB.
  - state enum: IDLE, RUN, DONE.
  - constants: SAT_POS16=16'h7FFF, SAT_NEG16=16'h8000, SAT_POS4=4'h7, SAT_NEG4=4'h8.
- One sub-module, nibble_cla_slice:
  - purely combinational 4-bit generate/propagate adder.
  - inputs a, b, cin; outputs sum, cout.
  - instantiated once.

## Test plan
- ADD 16'h1234 + 16'h0111 at T -> done at T+5, result 16'h1345, v=0, n=0, z=0.
- ADD 16'h7FFF + 16'h0001:
  - with SERIAL_ADD_SAT_EN -> 16'h7FFF, v=1.
  - without it -> 16'h8000, v=1, n=1.
- SUB 16'h0000 - 16'h0001 -> 16'hFFFF, v=0, n=1.
- SUB 16'h8000 - 16'h0001 -> 16'h8000, v=1 (SAT_EN).
- SUB 16'h0005 - 16'h0005 -> 16'h0000, z=1.
- PADDSB 16'h7F18 + 16'h1181 -> 16'h7099, v=1 (nibble 3 saturates to 7).
- Protocol and reset:
  - start held high throughout -> ops complete at T+5, T+11; busy never drops in RUN.
  - rst_n low at T+3 -> all outputs 0, no done pulse, next start completes normally.
